// File: rtl/adc_frame_reader.sv
// adc_frame_reader
//   Read-side controller for the dual-clock ADC sample FIFO. While idle it
//   drains stale words. On start it captures frame_len_i consecutive words
//   and presents them as a valid/ready stream with a last-word marker.
//
//   Ports
//     clk_sys_i, rst_i       system clock, async active-high reset
//     start_i, frame_len_i   capture request and frame length (sampled on start)
//     fifo_empty_i           FIFO empty flag
//     fifo_data_i            FIFO dout, valid one cycle after an accepted read
//     fifo_rd_en_o           FIFO read enable
//     m_tdata_o/m_tvalid_o/m_tready_i/m_tlast_o   output stream
//     busy_o                 capture in progress
//     done_o                 one-cycle pulse after the last word is accepted
//     test_mode_i            (ADC_FRAME_READER_TEST_PATTERN_EN only) frame
//                            words are generated as {k, ~k} instead of read
//
//   Optional feature macro: ADC_FRAME_READER_TEST_PATTERN_EN
module adc_frame_reader #(
    parameter int unsigned LenWidth  = 16,
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk_sys_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [LenWidth-1:0]  frame_len_i,
`ifdef ADC_FRAME_READER_TEST_PATTERN_EN
    input  logic                 test_mode_i,
`endif
    input  logic                 fifo_empty_i,
    input  logic [DataWidth-1:0] fifo_data_i,
    output logic                 fifo_rd_en_o,
    output logic [DataWidth-1:0] m_tdata_o,
    output logic                 m_tvalid_o,
    input  logic                 m_tready_i,
    output logic                 m_tlast_o,
    output logic                 busy_o,
    output logic                 done_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t                state_q, state_d;
    logic [LenWidth-1:0]   len_q, len_d;
    logic [LenWidth-1:0]   rd_cnt_q, rd_cnt_d;
    logic [LenWidth-1:0]   out_cnt_q, out_cnt_d;
    logic                  pend_q, pend_d;      // read issued last cycle
    logic                  disc_q, disc_d;      // that read belongs to the flush
    logic                  test_q;

    // Two-entry output buffer: head entry drives the stream ports directly.
    logic [DataWidth-1:0]  head_data_q, head_data_d;
    logic                  head_vld_q, head_vld_d;
    logic                  head_last_q, head_last_d;
    logic [DataWidth-1:0]  skid_data_q, skid_data_d;
    logic                  skid_vld_q, skid_vld_d;
    logic                  skid_last_q, skid_last_d;

    logic                  rd_en_c;
    logic                  vrd_c;               // generated (test pattern) read
    logic                  room_c;
    logic                  pop_c;
    logic                  push_c;
    logic                  push_last_c;
    logic [DataWidth-1:0]  push_data_c;
    logic [15:0]           pat_idx_c;

`ifdef ADC_FRAME_READER_TEST_PATTERN_EN
    logic test_d;
    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) test_q <= 1'b0;
        else       test_q <= test_d;
    end
`else
    assign test_q = 1'b0;
`endif

    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            rd_cnt_q    <= '0;
            out_cnt_q   <= '0;
            pend_q      <= 1'b0;
            disc_q      <= 1'b0;
            head_data_q <= '0;
            head_vld_q  <= 1'b0;
            head_last_q <= 1'b0;
            skid_data_q <= '0;
            skid_vld_q  <= 1'b0;
            skid_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            rd_cnt_q    <= rd_cnt_d;
            out_cnt_q   <= out_cnt_d;
            pend_q      <= pend_d;
            disc_q      <= disc_d;
            head_data_q <= head_data_d;
            head_vld_q  <= head_vld_d;
            head_last_q <= head_last_d;
            skid_data_q <= skid_data_d;
            skid_vld_q  <= skid_vld_d;
            skid_last_q <= skid_last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        rd_cnt_d    = rd_cnt_q;
        out_cnt_d   = out_cnt_q;
        head_data_d = head_data_q;
        head_vld_d  = head_vld_q;
        head_last_d = head_last_q;
        skid_data_d = skid_data_q;
        skid_vld_d  = skid_vld_q;
        skid_last_d = skid_last_q;
`ifdef ADC_FRAME_READER_TEST_PATTERN_EN
        test_d      = test_q;
`endif
        rd_en_c     = 1'b0;
        vrd_c       = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;

        // Occupancy plus in-flight read must stay below two; a pop in this
        // cycle is deliberately not credited.
        room_c = ({1'b0, head_vld_q} + {1'b0, skid_vld_q} + {1'b0, pend_q}) < 2'd2;
        pop_c  = head_vld_q && m_tready_i;
        push_c = pend_q && !disc_q;

        // rd_cnt_q already counts the returning read, so its index is rd_cnt_q-1.
        pat_idx_c   = 16'(rd_cnt_q - LenWidth'(1));
        push_last_c = (rd_cnt_q == len_q);
        push_data_c = test_q ? DataWidth'({pat_idx_c, ~pat_idx_c}) : fifo_data_i;

        unique case (state_q)
            ST_IDLE: begin
                rd_en_c = !fifo_empty_i;
                if (start_i && (frame_len_i != '0)) begin
                    len_d     = frame_len_i;
                    rd_cnt_d  = '0;
                    out_cnt_d = '0;
`ifdef ADC_FRAME_READER_TEST_PATTERN_EN
                    test_d    = test_mode_i;
`endif
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                busy_o = 1'b1;
                if ((rd_cnt_q < len_q) && room_c) begin
                    if (test_q) vrd_c   = 1'b1;
                    else        rd_en_c = !fifo_empty_i;
                end
                if (rd_en_c || vrd_c) rd_cnt_d = rd_cnt_q + LenWidth'(1);
                if (pop_c) begin
                    out_cnt_d = out_cnt_q + LenWidth'(1);
                    if (out_cnt_q == len_q - LenWidth'(1)) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Reads issued outside RUN return stale data and are tagged discard.
        pend_d = rd_en_c || vrd_c;
        disc_d = (state_q != ST_RUN);

        if (pop_c) begin
            if (skid_vld_q) begin
                head_data_d = skid_data_q;
                head_last_d = skid_last_q;
                head_vld_d  = 1'b1;
                skid_vld_d  = push_c;
                if (push_c) begin
                    skid_data_d = push_data_c;
                    skid_last_d = push_last_c;
                end
            end else if (push_c) begin
                head_data_d = push_data_c;
                head_last_d = push_last_c;
            end else begin
                head_vld_d  = 1'b0;
            end
        end else if (push_c) begin
            if (!head_vld_q) begin
                head_data_d = push_data_c;
                head_last_d = push_last_c;
                head_vld_d  = 1'b1;
            end else begin
                skid_data_d = push_data_c;
                skid_last_d = push_last_c;
                skid_vld_d  = 1'b1;
            end
        end
    end

    // Keep the read strobe low while reset is held.
    assign fifo_rd_en_o = rd_en_c && !rst_i;
    assign m_tdata_o    = head_data_q;
    assign m_tvalid_o   = head_vld_q;
    assign m_tlast_o    = head_vld_q && head_last_q;

endmodule
